// File: rtl/sgen_fcw_sweep.sv
// Frequency-control-word sweep generator feeding an NCO: sawtooth single sweep, or a
// continuous triangle sweep when SGEN_FCW_SWEEP_TRIANGLE_EN is defined.
module sgen_fcw_sweep #(
  parameter int unsigned gp_phase_accu_width = 16,
  parameter int unsigned gp_dwell_width      = 12
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_stop,
  input  logic                           i_mode,
  input  logic [gp_phase_accu_width-1:0] i_fcw_start,
  input  logic [gp_phase_accu_width-1:0] i_fcw_stop,
  input  logic [gp_phase_accu_width-1:0] i_fcw_step,
  input  logic [gp_dwell_width-1:0]      i_dwell,
  output logic [gp_phase_accu_width-1:0] o_fcw,
  output logic                           o_ena,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int unsigned W = gp_phase_accu_width;

`ifdef SGEN_FCW_SWEEP_TRIANGLE_EN
  typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;
`else
  typedef enum logic [1:0] {StIdle, StUp} state_e;
`endif

  state_e                    state_q, state_d;
  logic [W-1:0]              fcw_q, fcw_d;
  logic [W-1:0]              start_q, start_d, stop_q, stop_d, step_q, step_d;
  logic [gp_dwell_width-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
  logic                      ena_q, ena_d, busy_q, busy_d, done_q, done_d;

  // Steps are one bit wider so an overflow saturates at the endpoint instead of wrapping.
  logic [W:0]   up_sum;
  logic [W-1:0] up_next;
  logic         up_end, hold_end;

  assign up_sum   = {1'b0, fcw_q} + {1'b0, step_q};
  assign up_next  = (up_sum >= {1'b0, stop_q}) ? stop_q : up_sum[W-1:0];
  assign up_end   = (fcw_q >= stop_q) || (step_q == '0);
  assign hold_end = (cnt_q == dwell_q);

`ifdef SGEN_FCW_SWEEP_TRIANGLE_EN
  logic         mode_q, mode_d;
  logic [W:0]   dn_diff;
  logic [W-1:0] dn_next;
  logic         dn_end, degen;

  assign dn_diff = {1'b0, fcw_q} - {1'b0, step_q};
  assign dn_next = (dn_diff[W] || (dn_diff[W-1:0] <= start_q)) ? start_q : dn_diff[W-1:0];
  assign dn_end  = (fcw_q <= start_q) || (step_q == '0);
  // A degenerate range keeps bouncing between UP and DOWN on fcw_start.
  assign degen   = (stop_q <= start_q) || (step_q == '0);
`else
  logic unused_mode;
  assign unused_mode = i_mode;
`endif

  always_comb begin
    state_d = state_q;
    fcw_d   = fcw_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    done_d  = 1'b0;
`ifdef SGEN_FCW_SWEEP_TRIANGLE_EN
    mode_d  = mode_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_start && !i_stop) begin
          start_d = i_fcw_start;
          stop_d  = i_fcw_stop;
          step_d  = i_fcw_step;
          dwell_d = i_dwell;
`ifdef SGEN_FCW_SWEEP_TRIANGLE_EN
          mode_d  = i_mode;
`endif
          fcw_d   = i_fcw_start;
          cnt_d   = '0;
          state_d = StUp;
        end
      end
      StUp: begin
        if (!hold_end) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (!up_end) begin
            fcw_d = up_next;
          end
`ifdef SGEN_FCW_SWEEP_TRIANGLE_EN
          else if (mode_q) begin
            state_d = StDown;
            if (!degen) fcw_d = dn_next;
          end
`endif
          else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
`ifdef SGEN_FCW_SWEEP_TRIANGLE_EN
      StDown: begin
        if (!hold_end) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (!dn_end) begin
            fcw_d = dn_next;
          end else begin
            state_d = StUp;
            if (!degen) fcw_d = up_next;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (i_stop) begin
      state_d = StIdle;
      fcw_d   = fcw_q;
      cnt_d   = '0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != StIdle);
    ena_d  = busy_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      fcw_q   <= '0;
      cnt_q   <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SGEN_FCW_SWEEP_TRIANGLE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      fcw_q   <= fcw_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SGEN_FCW_SWEEP_TRIANGLE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign o_fcw  = fcw_q;
  assign o_ena  = ena_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule
